// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S frame controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } i2s_state_e;

  localparam int DEF_BITWIDTH  = 24;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_BCLK_DIV  = 32;
  localparam int DEF_MCLK_DIV  = 4;

endpackage

// File: rtl/i2s_mclk_div.sv
// Free-running mclk divider: high for MCLK_DIV/2 cycles, then low for MCLK_DIV/2.
module i2s_mclk_div
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV = DEF_MCLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic mclk_o
);

  localparam int CW = $clog2(MCLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(MCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(MCLK_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    mclk_d = (cnt_q < CNT_HALF);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
    end
  end

  assign mclk_o = mclk_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S frame sequencer: bclk/lrck generation, one-entry sample holding register,
// per-frame load/shift strobes for the serializer and underrun accounting.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int BITWIDTH  = DEF_BITWIDTH,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCLK_DIV  = DEF_BCLK_DIV,
  parameter int MCLK_DIV  = DEF_MCLK_DIV
) (
  input  logic                ctl_clk,
  input  logic                ctl_rst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BITWIDTH-1:0] s_data_l,
  input  logic [BITWIDTH-1:0] s_data_r,
  input  logic                underrun_clr,
  output logic                i2s_mclk,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                tx_load,
  output logic                tx_shift,
  output logic [BITWIDTH-1:0] tx_data_l,
  output logic [BITWIDTH-1:0] tx_data_r,
  output logic                busy,
  output logic [15:0]         underrun_cnt
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT  = BIT_W'(SLOT_BITS);

  i2s_state_e          state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                hold_full_q, hold_full_d;
  logic [BITWIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [BITWIDTH-1:0] tx_data_l_q, tx_data_l_d, tx_data_r_q, tx_data_r_d;
  logic                s_ready_q, s_ready_d;
  logic                bclk_q, bclk_d, lrck_q, lrck_d;
  logic                tx_load_q, tx_load_d, tx_shift_q, tx_shift_d;
  logic                busy_q, busy_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;

  logic frame_end, boundary, accept, active;

  always_comb begin
    active    = (state_q != ST_IDLE);
    frame_end = (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);
    boundary  = (state_q == ST_RUN) && (div_cnt_q == '0) && (bit_cnt_q == '0);
    accept    = s_valid && s_ready_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)    state_d = ST_RUN;
      ST_RUN:  if (!enable)   state_d = ST_STOP;
      ST_STOP: if (frame_end) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase

    div_cnt_d = '0;
    bit_cnt_d = '0;
    if (active) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      if (div_cnt_q == DIV_LAST)
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end

    // The boundary drains the holding register before a same-cycle accept refills it.
    hold_full_d    = hold_full_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    tx_data_l_d    = tx_data_l_q;
    tx_data_r_d    = tx_data_r_q;
    underrun_cnt_d = underrun_cnt_q;
    if (boundary) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        tx_data_l_d = hold_l_q;
        tx_data_r_d = hold_r_q;
      end else begin
        tx_data_l_d = '0;
        tx_data_r_d = '0;
        if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_data_l;
      hold_r_d    = s_data_r;
    end
    if (state_d == ST_IDLE) hold_full_d = 1'b0;
    if (underrun_clr)       underrun_cnt_d = '0;

    s_ready_d  = (state_d == ST_RUN) && !hold_full_d;
    bclk_d     = active && (div_cnt_q >= DIV_HALF);
    lrck_d     = active && (bit_cnt_q >= BIT_RIGHT);
    tx_load_d  = boundary;
    tx_shift_d = active && (div_cnt_q == '0) && (bit_cnt_q != '0);
    busy_d     = active;
  end

  always_ff @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      hold_full_q    <= 1'b0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      tx_data_l_q    <= '0;
      tx_data_r_q    <= '0;
      s_ready_q      <= 1'b0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      tx_load_q      <= 1'b0;
      tx_shift_q     <= 1'b0;
      busy_q         <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      hold_full_q    <= hold_full_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      tx_data_l_q    <= tx_data_l_d;
      tx_data_r_q    <= tx_data_r_d;
      s_ready_q      <= s_ready_d;
      bclk_q         <= bclk_d;
      lrck_q         <= lrck_d;
      tx_load_q      <= tx_load_d;
      tx_shift_q     <= tx_shift_d;
      busy_q         <= busy_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  i2s_mclk_div #(.MCLK_DIV(MCLK_DIV)) u_mclk_div (
    .clk_i  (ctl_clk),
    .rst_i  (ctl_rst),
    .mclk_o (i2s_mclk)
  );

  assign s_ready      = s_ready_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign tx_load      = tx_load_q;
  assign tx_shift     = tx_shift_q;
  assign tx_data_l    = tx_data_l_q;
  assign tx_data_r    = tx_data_r_q;
  assign busy         = busy_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl with default geometry (frame = 64 bclk x 32 clk = 2048 cycles).
module tb_i2s_frame_ctrl;

  logic        ctl_clk = 1'b0;
  logic        ctl_rst = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data_l = '0;
  logic [23:0] s_data_r = '0;
  logic        underrun_clr = 1'b0;
  logic        i2s_mclk, i2s_bclk, i2s_lrck, tx_load, tx_shift, busy;
  logic [23:0] tx_data_l, tx_data_r;
  logic [15:0] underrun_cnt;

  int n_chk = 0, n_fail = 0;
  int run_t = 0;
  int n_load = 0, n_shift = 0, n_acc = 0;

  always #5 ctl_clk = ~ctl_clk;

  i2s_frame_ctrl dut (
    .ctl_clk      (ctl_clk),
    .ctl_rst      (ctl_rst),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data_l     (s_data_l),
    .s_data_r     (s_data_r),
    .underrun_clr (underrun_clr),
    .i2s_mclk     (i2s_mclk),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .tx_load      (tx_load),
    .tx_shift     (tx_shift),
    .tx_data_l    (tx_data_l),
    .tx_data_r    (tx_data_r),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // run_t = n means we sit in counter interval n; outputs show interval n-1.
  task automatic tick();
    @(posedge ctl_clk);
    #1;
    run_t++;
    if (tx_load) n_load++;
    if (tx_shift) n_shift++;
    if (s_valid && s_ready) n_acc++;
  endtask

  task automatic run_to(input int target);
    while (run_t < target) tick();
  endtask

  logic mk[40];
  int   bad, highs;

  initial begin
    repeat (3) tick();
    chk("rst_flags", {i2s_mclk, i2s_bclk, i2s_lrck, tx_load, tx_shift, busy, s_ready}, 0);
    chk("rst_underrun", underrun_cnt, 0);
    chk("rst_tx_data", {tx_data_l, tx_data_r}, 0);
    ctl_rst = 1'b0;

    // Idle: mclk period 4, everything else quiet.
    bad = 0; highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      mk[i] = i2s_mclk;
      if (mk[i]) highs++;
      if (i >= 2 && mk[i] == mk[i-2]) bad++;
      if (i >= 4 && mk[i] != mk[i-4]) bad++;
    end
    chk("mclk_period", bad, 0);
    chk("mclk_duty", highs, 20);
    chk("idle_flags", {i2s_bclk, i2s_lrck, busy, s_ready}, 0);
    chk("idle_underrun", underrun_cnt, 0);

    // Run 1: pair offered with enable; first boundary underruns, frame 1 carries it.
    s_data_l = 24'h123456; s_data_r = 24'hABCDEF; s_valid = 1'b1; enable = 1'b1;
    run_t = -1;
    tick();
    chk("run_ready0", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("f0_load", tx_load, 1);
    chk("f0_data", {tx_data_l, tx_data_r}, 0);
    chk("f0_underrun", underrun_cnt, 1);
    chk("f0_ready_after_acc", s_ready, 0);
    n_load = 0; n_shift = 0;
    run_to(16);   chk("bclk_low", i2s_bclk, 0);
    run_to(17);   chk("bclk_high", i2s_bclk, 1);
    run_to(1024); chk("lrck_left", i2s_lrck, 0);
    run_to(1025); chk("lrck_right", i2s_lrck, 1);
    run_to(2049);
    chk("f1_loads", n_load, 1);
    chk("f1_shifts", n_shift, 63);
    chk("f1_load", tx_load, 1);
    chk("f1_data_l", tx_data_l, 24'h123456);
    chk("f1_data_r", tx_data_r, 24'hABCDEF);
    chk("f1_underrun", underrun_cnt, 1);
    n_load = 0; n_shift = 0;
    run_to(4096);
    chk("f2_loads", n_load, 0);
    chk("f2_shifts", n_shift, 63);
    run_to(4097);
    chk("f2_underrun", underrun_cnt, 2);
    chk("f2_data_l", tx_data_l, 0);
    run_to(6145);
    chk("f3_underrun", underrun_cnt, 3);
    chk("f3_data_r", tx_data_r, 0);
    run_to(8192);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_load", tx_load, 1);
    chk("clr_prio", underrun_cnt, 0);

    // Drop enable at bit 10 of frame 5; a pair accepted there must be discarded.
    run_to(10560);
    enable = 1'b0; s_valid = 1'b1; s_data_l = 24'h777777; s_data_r = 24'h888888;
    tick();
    s_valid = 1'b0;
    chk("stop_ready", s_ready, 0);
    chk("stop_busy", busy, 1);
    n_load = 0;
    run_to(12288);
    chk("stop_last_busy", busy, 1);
    chk("stop_last_clk", {i2s_bclk, i2s_lrck}, 2'b11);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_clk", {i2s_bclk, i2s_lrck}, 2'b00);
    chk("stop_no_load", n_load, 0);
    chk("stop_underrun", underrun_cnt, 1);

    // Run 2: discarded pair must not reappear; reset mid-frame at bit 40.
    enable = 1'b1;
    run_t = -1;
    tick();
    tick();
    chk("r2_load", tx_load, 1);
    chk("r2_discard", {tx_data_l, tx_data_r}, 0);
    chk("r2_underrun", underrun_cnt, 2);
    run_to(1281);
    chk("r2_pre_rst", {busy, i2s_lrck}, 2'b11);
    ctl_rst = 1'b1;
    #1;
    chk("arst_flags", {i2s_mclk, i2s_bclk, i2s_lrck, tx_load, tx_shift, busy, s_ready}, 0);
    chk("arst_underrun", underrun_cnt, 0);
    s_data_l = 24'h5A5A5A; s_data_r = 24'h0F0F0F; s_valid = 1'b1;
    tick();
    tick();
    ctl_rst = 1'b0;

    // Run 3: fresh frame after reset, back-to-back offers.
    run_t = -1; n_acc = 0;
    tick();
    tick();
    chk("r3_load", tx_load, 1);
    chk("r3_data", {tx_data_l, tx_data_r}, 0);
    chk("r3_underrun", underrun_cnt, 1);
    chk("r3_lrck", i2s_lrck, 0);
    chk("r3_ready_full", s_ready, 0);
    run_to(32); chk("r3_shift_off", tx_shift, 0);
    run_to(33); chk("r3_shift_on", tx_shift, 1);
    run_to(2048);
    chk("r3_ready_held", s_ready, 0);
    tick();
    chk("r3_f1_load", tx_load, 1);
    chk("r3_f1_data", {tx_data_l, tx_data_r}, 48'h5A5A5A_0F0F0F);
    chk("r3_ready_free", s_ready, 1);
    tick();
    chk("r3_ready_reacc", s_ready, 0);
    run_to(4200);
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_underrun", underrun_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
